uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver with a receive FIFO and an interrupt request, the successor to the bare serial input on the computer top level. It oversamples the asynchronous rx line, checks framing and (optionally) parity, and buffers received words. The CPU drains words through a first-word-fall-through read port. irq feeds the CPU interrupt input (intr).

Parameters:
CLKS_PER_BIT, 16, clock cycles per bit period; minimum 4; 160 ns at 100 MHz sim clock.
DATA_BITS, 8, data bits per frame; range 5..9.
DEPTH, 8, FIFO depth in words; power of two, at least 2.
IRQ_LEVEL, 1, FIFO count at or above which irq asserts; range 1..DEPTH.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk
uart_rx  in  1  asynchronous serial input; idles high
rd_en  in  1  pop the FIFO head; ignored when empty
rd_data  out  DATA_BITS  FIFO head word, valid while !empty
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  clog2(DEPTH)+1  words held
frame_err  out  1  sticky: stop bit sampled 0
overrun  out  1  sticky: frame completed while FIFO full
parity_err  out  1  sticky: parity mismatch; tied 0 without UART_PARITY_EN
err_clr  in  1  clears all sticky error flags
irq  out  1  interrupt request, level

Behaviour:
- Reset (reset==0 at a clk edge): FSM goes to IDLE. FIFO pointers and count go to 0. empty=1, full=0, all error flags 0, irq=0, rd_data=0. Both synchroniser flops load 1. Reset overrides every other input, including mid-frame; a partial frame is discarded.
- Input: 2-flop synchroniser. All sampling uses the synchronised bit, rxs, which adds 2 cycles of latency.
- Bit counter: counts 0..CLKS_PER_BIT-1.
- FSM states:
  - IDLE: when rxs==0, go to START and clear the counter.
  - START: at count CLKS_PER_BIT/2-1, sample rxs. If 0, go to DATA and clear the counter. If 1, treat as a glitch and return to IDLE with no error.
  - DATA: every CLKS_PER_BIT cycles, sample one bit into the shift register, LSB first. After DATA_BITS samples, go to PARITY (feature enabled) or STOP.
  - PARITY: sample after CLKS_PER_BIT cycles and compare with the computed parity. On mismatch, set parity_err; the word is still pushed.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rxs==1: push the word and return to IDLE.
    - rxs==0: set frame_err, discard the word, go to BREAK.
  - BREAK: wait for rxs==1, then go to IDLE. This prevents a held-low line from re-triggering.
- Timing: every sample lands mid-bit. The word is visible on rd_data one cycle after the stop-bit sample.
- Push while full: the word is dropped and overrun is set, unless rd_en is also asserted in that cycle. In that case the pop and push both happen, count is unchanged, and there is no overrun.
- Push and pop in the same cycle, not full: count is unchanged.
- Pop: rd_en with !empty advances the read pointer. The new head appears on the next cycle.
- Pointers: log2(DEPTH) bits wide and wrap naturally. count is maintained separately.
- Sticky flags: err_clr clears all flags. If a new error is set in the same cycle as err_clr, the set wins.
- irq: registered; equals (count>=IRQ_LEVEL) | frame_err | overrun | parity_err.

Optional Feature:
UART_PARITY_EN:
- Defined: adds the PARITY state and a parameter PARITY_ODD (default 0, meaning even parity); parity_err is live.
- Undefined: no PARITY state, DATA goes straight to STOP, and parity_err is constant 0.
- Port list is identical in both builds.

Decomposition:
- Package uart_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK) and the clog2 width helper constant function.
- One sub-module: sync_fifo, parametrised by WIDTH and DEPTH, providing push/pop, FWFT head, count, empty and full. It is reusable elsewhere in the computer.

Test Plan:
1. Reset then idle line: hold reset=0 for 2 cycles, uart_rx=1. Expect empty=1, count=0, irq=0, all flags 0, rd_data=0.
2. Frame 0x55 at 16 clocks/bit with stop=1. Expect the word pushed 1 cycle after the stop-bit sample: rd_data=0x55, count=1, irq=1. Then pulse rd_en: empty=1, irq=0.
3. Frame with data bits 1,0,1,0,0,1,1,0 (LSB first) and the line then held low for 3000 ns. Expect frame_err=1, irq=1, count=0, FSM in BREAK. Raise the line: FSM returns to IDLE. Pulse err_clr: frame_err=0.
4. Glitch: uart_rx low for 4 cycles. Expect a return to IDLE with no push and no flags.
5. Overrun: send DEPTH+1 frames with no reads. Expect count=DEPTH, full=1, overrun=1, and the FIFO holds the first DEPTH words in order. Repeat, but pulse rd_en in the same cycle as the final push: overrun stays 0 and count stays DEPTH.
6. UART_PARITY_EN, even parity: send 0x07 with parity bit 0. Expect parity_err=1 and the word still pushed. Send 0x07 with parity bit 1: parity_err stays clear after err_clr.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: FSM state encoding and a
// constant-function width helper used to size counters and pointers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_t;

  // Number of bits needed to index n items (minimum 1).
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head word is presented while
// !empty, and a push into a full FIFO is accepted only alongside a pop.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    empty,
  output logic                    full,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_W);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap on their own; count is tracked separately so full and
  // empty never need pointer comparison.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding a FWFT FIFO with sticky error flags
// and a level interrupt. Define UART_PARITY_EN to add the parity bit check.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int DEPTH        = 8,
  parameter int IRQ_LEVEL    = 1
`ifdef UART_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   uart_rx,
  input  logic                   rd_en,
  output logic [DATA_BITS-1:0]   rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [clog2(DEPTH):0]  count,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   parity_err,
  input  logic                   err_clr,
  output logic                   irq
);

  localparam int CW   = clog2(CLKS_PER_BIT);
  localparam int BW   = clog2(DATA_BITS);
  localparam int CNTW = clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [CNTW-1:0] IRQ_LVL  = CNTW'(IRQ_LEVEL);

  logic rx_meta, rxs;
  uart_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_idx, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic push_word, fe_set, ov_set;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
    end
  end

`ifdef UART_PARITY_EN
  logic pe_set;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_n     = bit_idx;
    shift_n   = shift;
    push_word = 1'b0;
    fe_set    = 1'b0;
`ifdef UART_PARITY_EN
    pe_set    = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxs) state_n = START;
      end
      START: begin
        // A start bit that has gone high by mid-bit is a line glitch.
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          shift_n = {rxs, shift[DATA_BITS-1:1]};
          bit_n   = bit_idx + 1'b1;
          if (bit_idx == BIT_LAST) begin
`ifdef UART_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          pe_set  = (rxs != ((^shift) ^ PARITY_ODD));
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rxs) begin
            push_word = 1'b1;
            state_n   = IDLE;
          end else begin
            fe_set  = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        // Hold here until the line returns high so a stuck-low line
        // cannot be mistaken for a stream of start bits.
        cnt_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // A push into a full FIFO survives only if the CPU pops in the same cycle.
  assign ov_set = push_word & full & ~rd_en;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_word),
    .wr_data (shift),
    .pop     (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  // Sticky flags: a fresh error in the err_clr cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      frame_err <= fe_set | (frame_err & ~err_clr);
      overrun   <= ov_set | (overrun & ~err_clr);
      irq       <= (count >= IRQ_LVL) | frame_err | overrun | parity_err;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset) parity_err <= 1'b0;
    else        parity_err <= pe_set | (parity_err & ~err_clr);
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random frames
// scored against a queue-based model of the received word stream and flags.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int CPB       = 16;
  localparam int DB        = 8;
  localparam int DEPTH     = 8;
  localparam int IRQ_LEVEL = 1;
`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int CNTW      = clog2(DEPTH) + 1;
  localparam int FRAME_CYC = (DB + PAR + 2) * CPB;
  // Line bit index where the parity (or stop) bit begins, in cycles.
  localparam int TAIL_CYC  = (DB + 1) * CPB;
  // Negedge index (counted from driving the start bit) at which a pushed word
  // is first visible: 2 sync flops, 1 cycle to leave IDLE, half a bit to the
  // start sample, then one full bit per data/parity/stop bit.
  localparam int PUSH_VIS  = 3 + CPB / 2 + (DB + PAR + 1) * CPB;

  logic            clk;
  logic            reset;
  logic            uart_rx;
  logic            rd_en;
  logic [DB-1:0]   rd_data;
  logic            empty;
  logic            full;
  logic [CNTW-1:0] count;
  logic            frame_err;
  logic            overrun;
  logic            parity_err;
  logic            err_clr;
  logic            irq;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .DEPTH        (DEPTH),
    .IRQ_LEVEL    (IRQ_LEVEL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .err_clr    (err_clr),
    .irq        (irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  logic [DB-1:0] exp_q[$];
  bit m_fe, m_ov, m_pe;
  bit chk_en;
  int n_tests;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("count", 32'(count), 32'(exp_q.size()));
      check("empty", 32'(empty), 32'(exp_q.size() == 0));
      check("full", 32'(full), 32'(exp_q.size() == DEPTH));
      if (exp_q.size() > 0) check("rd_data", 32'(rd_data), 32'(exp_q[0]));
      check("frame_err", 32'(frame_err), 32'(m_fe));
      check("overrun", 32'(overrun), 32'(m_ov));
      check("parity_err", 32'(parity_err), 32'(m_pe));
      check("irq", 32'(irq), 32'((exp_q.size() >= IRQ_LEVEL) | m_fe | m_ov | m_pe));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic settle();
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
  endtask

  task automatic pop();
    @(negedge clk);
    chk_en = 1'b0;
    rd_en  = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    settle();
  endtask

  task automatic clear_errs();
    @(negedge clk);
    chk_en  = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_fe = 0;
    m_ov = 0;
    m_pe = 0;
    settle();
  endtask

  // Drives one frame; the line is left at the stop-bit level afterwards.
  task automatic send_frame(input logic [DB-1:0] data, input bit par_ok, input bit stop_bit,
                            input bit pop_at_push, input bit chk_lat);
    int fbits[$];
    int seen_at;
    seen_at = -1;
    fbits.push_back(0);
    for (int i = 0; i < DB; i++) fbits.push_back(int'(data[i]));
    if (PAR != 0) fbits.push_back(int'((^data) ^ !par_ok));
    fbits.push_back(int'(stop_bit));
    for (int c = 0; c < FRAME_CYC; c++) begin
      @(negedge clk);
      if (c == TAIL_CYC) chk_en = 1'b0;
      uart_rx = fbits[c / CPB][0];
      rd_en   = pop_at_push && (c == PUSH_VIS - 1);
      if (seen_at < 0 && int'(count) != exp_q.size()) seen_at = c;
    end
    if (PAR != 0 && !par_ok) m_pe = 1;
    if (!stop_bit) begin
      m_fe = 1;
    end else if (pop_at_push) begin
      void'(exp_q.pop_front());
      exp_q.push_back(data);
    end else if (exp_q.size() == DEPTH) begin
      m_ov = 1;
    end else begin
      exp_q.push_back(data);
    end
    if (chk_lat) check("push_latency", 32'(seen_at), 32'(PUSH_VIS));
    settle();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    chk_en = 1'b0;
    reset  = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    m_fe = 0;
    m_ov = 0;
    m_pe = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DB-1:0] d;
    bit pok, stp;
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    reset   = 1'b0;
    uart_rx = 1'b1;
    rd_en   = 1'b0;
    err_clr = 1'b0;

    // 1. reset, idle line
    reset_dut();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_flags", 32'({frame_err, overrun, parity_err}), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    reset = 1'b1;
    settle();

    // 2. single good frame, then pop
    send_frame(8'h55, 1, 1, 0, 1);
    check("t2_rd_data", 32'(rd_data), 32'h55);
    check("t2_count", 32'(count), 32'd1);
    check("t2_irq", 32'(irq), 32'd1);
    pop();
    check("t2_empty", 32'(empty), 32'd1);
    check("t2_irq_low", 32'(irq), 32'd0);

    // 3. framing error with line held low, then release and clear
    send_frame(8'h65, 1, 0, 0, 0);
    repeat (300) @(negedge clk);
    check("t3_frame_err", 32'(frame_err), 32'd1);
    check("t3_irq", 32'(irq), 32'd1);
    check("t3_count", 32'(count), 32'd0);
    check("t3_state_break", 32'(dut.state), 32'(BREAK));
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    check("t3_state_idle", 32'(dut.state), 32'(IDLE));
    clear_errs();
    check("t3_fe_clr", 32'(frame_err), 32'd0);

    // 4. short glitch on the line
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    check("t4_state", 32'(dut.state), 32'(IDLE));
    check("t4_count", 32'(count), 32'd0);

    // 5a. overrun after DEPTH+1 frames, FIFO keeps the first DEPTH words
    for (int i = 0; i <= DEPTH; i++) send_frame(DB'(8'h10 + i), 1, 1, 0, i < DEPTH);
    check("t5_full", 32'(full), 32'd1);
    check("t5_overrun", 32'(overrun), 32'd1);
    check("t5_count", 32'(count), 32'(DEPTH));
    check("t5_head", 32'(rd_data), 32'h10);
    repeat (DEPTH) pop();
    clear_errs();

    // 5b. final push coincides with a pop: no overrun
    for (int i = 0; i < DEPTH; i++) send_frame(DB'(8'hA0 + i), 1, 1, 0, 1);
    send_frame(8'h3C, 1, 1, 1, 0);
    check("t5b_overrun", 32'(overrun), 32'd0);
    check("t5b_count", 32'(count), 32'(DEPTH));
    check("t5b_head", 32'(rd_data), 32'hA1);
    repeat (DEPTH) pop();
    pop();  // pop on empty is ignored

`ifdef UART_PARITY_EN
    // 6. even parity
    send_frame(8'h07, 0, 1, 0, 1);
    check("t6_parity_err", 32'(parity_err), 32'd1);
    check("t6_pushed", 32'(rd_data), 32'h07);
    clear_errs();
    send_frame(8'h07, 1, 1, 0, 1);
    check("t6_parity_ok", 32'(parity_err), 32'd0);
    repeat (2) pop();
`endif

    // random frames, pops and clears
    for (int n = 0; n < 30; n++) begin
      d   = DB'($urandom);
      pok = ($urandom_range(0, 3) != 0);
      stp = ($urandom_range(0, 9) != 0);
      send_frame(d, pok, stp, 0, stp && exp_q.size() < DEPTH);
      if (!stp) begin
        repeat ($urandom_range(5, 40)) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
      end
      repeat ($urandom_range(0, 2)) pop();
      if ($urandom_range(0, 4) == 0) clear_errs();
    end

    // reset in the middle of a frame discards it and the FIFO contents
    send_frame(8'hC3, 1, 1, 0, 0);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (40) @(negedge clk);
    reset_dut();
    uart_rx = 1'b1;
    reset   = 1'b1;
    @(negedge clk);
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    check("mid_rst_count", 32'(count), 32'd0);
    settle();
    send_frame(8'h9A, 1, 1, 0, 1);
    check("post_rst_data", 32'(rd_data), 32'h9A);
    pop();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
